// File: rtl/timer_ctrl_pkg.sv
// timer_pkg: shared types and constants for the timer controller.
//   state_t      : controller FSM encoding (IDLE, RUN, PAUSE, DONE)
//   MODE_ONESHOT : stop in DONE after the first terminal event
//   MODE_RELOAD  : clear the count on terminal and keep running
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: config/control/status bundle of the timer controller.
//   cfg_load/cfg_period/cfg_presc/cfg_mode : configuration write
//   start/stop/irq_ack                     : run control and interrupt acknowledge
//   count/busy/done_pulse/irq/overrun/cfg_err : registered status
// master = host side, slave = timer_ctrl.
interface timer_ctrl_if #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
);
   logic               cfg_load;
   logic [WIDTH-1:0]   cfg_period;
   logic [PRESC_W-1:0] cfg_presc;
   logic               cfg_mode;
   logic               start;
   logic               stop;
   logic               irq_ack;
   logic [WIDTH-1:0]   count;
   logic               busy;
   logic               done_pulse;
   logic               irq;
   logic               overrun;
   logic               cfg_err;

   modport master (
      output cfg_load, cfg_period, cfg_presc, cfg_mode, start, stop, irq_ack,
      input  count, busy, done_pulse, irq, overrun, cfg_err
   );

   modport slave (
      input  cfg_load, cfg_period, cfg_presc, cfg_mode, start, stop, irq_ack,
      output count, busy, done_pulse, irq, overrun, cfg_err
   );
endinterface

// File: rtl/sync_tff_counter.sv
// sync_tff_counter: synchronous up counter built from toggle flops.
//   clk, rst : clock, async active-high reset (q -> 0)
//   en       : count enable, advances q by one
//   clr      : synchronous clear, wins over en
//   q        : counter value
module sync_tff_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   // t[i] = en & q[0] & ... & q[i-1], built as a ripple of ANDs
   logic [WIDTH-1:0] t;

   assign t[0] = en;

   genvar i;
   generate
      for (i = 1; i < WIDTH; i++) begin : g_chain
         assign t[i] = t[i-1] & q[i-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable timer around a T-flop up counter.
//   clk, rst : clock, async active-high reset
//   bus      : timer_ctrl_if slave (config, start/stop, irq_ack, status)
// A tick is produced every presc+1 clocks while running; each tick either
// advances the count or, when count == period, raises a terminal event
// (done_pulse, irq) and then reloads or stops depending on mode.
//
// state | meaning
// IDLE  | after reset, never started
// RUN   | prescaler and counter active
// PAUSE | stopped mid-count, count and prescaler hold
// DONE  | one-shot reached terminal, count holds at period
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input logic         clk,
   input logic         rst,
   timer_ctrl_if.slave bus
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   period;
   logic [PRESC_W-1:0] presc;
   logic               mode;
   logic [PRESC_W-1:0] presc_cnt;
   logic [WIDTH-1:0]   count_q;

   logic ctr_en;
   logic ctr_clr;
   logic presc_clr;
   logic presc_inc;
   logic terminal;

   sync_tff_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (ctr_en),
      .clr (ctr_clr),
      .q   (count_q)
   );

   assign bus.count = count_q;

   // stop beats start in every state; a stopping RUN cycle produces no tick
   always_comb begin
      state_nxt = state;
      ctr_en    = 1'b0;
      ctr_clr   = 1'b0;
      presc_clr = 1'b0;
      presc_inc = 1'b0;
      terminal  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start && !bus.stop) begin
               state_nxt = RUN;
               ctr_clr   = 1'b1;
               presc_clr = 1'b1;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_nxt = PAUSE;
            end else if (presc_cnt == presc) begin
               presc_clr = 1'b1;
               if (count_q == period) begin
                  terminal = 1'b1;
                  if (mode == MODE_RELOAD) begin
                     ctr_clr = 1'b1;
                  end else begin
                     state_nxt = DONE;
                  end
               end else begin
                  // a count above period (lowered while paused) wraps through 0
                  ctr_en = 1'b1;
               end
            end else begin
               presc_inc = 1'b1;
            end
         end
         PAUSE: begin
            if (bus.start && !bus.stop) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         period         <= '0;
         presc          <= '0;
         mode           <= MODE_ONESHOT;
         presc_cnt      <= '0;
         bus.busy       <= 1'b0;
         bus.done_pulse <= 1'b0;
         bus.irq        <= 1'b0;
         bus.overrun    <= 1'b0;
         bus.cfg_err    <= 1'b0;
      end else begin
         state    <= state_nxt;
         bus.busy <= (state_nxt == RUN) || (state_nxt == PAUSE);

         if (presc_clr) begin
            presc_cnt <= '0;
         end else if (presc_inc) begin
            presc_cnt <= presc_cnt + 1'b1;
         end

         if (bus.cfg_load && (state != RUN)) begin
            period <= bus.cfg_period;
            presc  <= bus.cfg_presc;
            mode   <= bus.cfg_mode;
         end
         bus.cfg_err <= bus.cfg_load && (state == RUN);

         bus.done_pulse <= terminal;

         // a new event wins over ack for irq; ack wins for overrun
         if (terminal) begin
            bus.irq <= 1'b1;
         end else if (bus.irq_ack) begin
            bus.irq <= 1'b0;
         end

         if (bus.irq_ack) begin
            bus.overrun <= 1'b0;
         end else if (terminal && bus.irq) begin
            bus.overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl with WIDTH=4, PRESC_W=4.
module tb_timer_ctrl;
   import timer_pkg::*;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   timer_ctrl_if #(.WIDTH(4), .PRESC_W(4)) bus ();

   timer_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance past the next rising edge; inputs change and outputs are sampled here
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic cfg(input int p, input int s, input logic m);
      logic [3:0] pv;
      logic [3:0] sv;
      pv = p[3:0];
      sv = s[3:0];
      bus.cfg_load   = 1'b1;
      bus.cfg_period = pv;
      bus.cfg_presc  = sv;
      bus.cfg_mode   = m;
      step();
      bus.cfg_load = 1'b0;
   endtask

   task automatic go();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      n_pass         = 0;
      n_total        = 0;
      rst            = 1'b1;
      bus.cfg_load   = 1'b0;
      bus.cfg_period = '0;
      bus.cfg_presc  = '0;
      bus.cfg_mode   = 1'b0;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.irq_ack    = 1'b0;
      step();
      chk("rst_count", bus.count, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_irq", bus.irq, 0);
      chk("rst_done", bus.done_pulse, 0);
      chk("rst_ovr", bus.overrun, 0);
      chk("rst_cfgerr", bus.cfg_err, 0);
      rst = 1'b0;
      step();

      // one-shot P=5 S=0
      cfg(5, 0, MODE_ONESHOT);
      go();
      chk("os_busy0", bus.busy, 1);
      chk("os_cnt0", bus.count, 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("os_cnt", bus.count, k);
         chk("os_nodone", bus.done_pulse, 0);
      end
      step();
      chk("os_done", bus.done_pulse, 1);
      chk("os_irq", bus.irq, 1);
      chk("os_busy_end", bus.busy, 0);
      chk("os_hold", bus.count, 5);
      step();
      chk("os_done_1cyc", bus.done_pulse, 0);
      chk("os_hold2", bus.count, 5);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("os_ack", bus.irq, 0);

      // auto-reload P=3 S=1: terminal every 8 clocks, no ack
      do_reset();
      cfg(3, 1, MODE_RELOAD);
      go();
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("rl_cnt", bus.count, (i % 8) / 2);
         chk("rl_done", bus.done_pulse, (i % 8) == 0);
         chk("rl_busy", bus.busy, 1);
         chk("rl_irq", bus.irq, i >= 8);
         chk("rl_ovr", bus.overrun, i >= 16);
      end

      // reload P=2 S=0: overrun, then ack coinciding with a terminal
      do_reset();
      cfg(2, 0, MODE_RELOAD);
      go();
      step(); step(); step();
      chk("ov_done1", bus.done_pulse, 1);
      chk("ov_irq1", bus.irq, 1);
      chk("ov_ovr1", bus.overrun, 0);
      step(); step(); step();
      chk("ov_done2", bus.done_pulse, 1);
      chk("ov_ovr2", bus.overrun, 1);
      step(); step();
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("ack_term_done", bus.done_pulse, 1);
      chk("ack_term_irq", bus.irq, 1);
      chk("ack_term_ovr", bus.overrun, 0);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("ack_irq", bus.irq, 0);
      chk("ack_ovr", bus.overrun, 0);

      // stop / resume, start+stop together, cfg_load during RUN
      do_reset();
      cfg(7, 0, MODE_ONESHOT);
      go();
      step(); step();
      chk("sr_cnt2", bus.count, 2);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("sr_pause_cnt", bus.count, 2);
      chk("sr_pause_busy", bus.busy, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("sr_frozen", bus.count, 2);
      end
      go();
      chk("sr_resume_edge", bus.count, 2);
      step();
      chk("sr_cnt3", bus.count, 3);
      step();
      chk("sr_cnt4", bus.count, 4);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("ss_cnt", bus.count, 4);
      step();
      chk("ss_paused", bus.count, 4);
      chk("ss_busy", bus.busy, 1);
      go();
      step();
      chk("ss_cnt5", bus.count, 5);
      bus.cfg_load   = 1'b1;
      bus.cfg_period = 4'd9;
      step();
      bus.cfg_load = 1'b0;
      chk("ce_pulse", bus.cfg_err, 1);
      chk("ce_cnt6", bus.count, 6);
      step();
      chk("ce_pulse_end", bus.cfg_err, 0);
      chk("ce_cnt7", bus.count, 7);
      step();
      chk("ce_period_kept", bus.done_pulse, 1);
      chk("ce_cnt_hold", bus.count, 7);

      // same load in IDLE is accepted: next run ends at 9
      do_reset();
      cfg(9, 0, MODE_ONESHOT);
      chk("ce_idle_noerr", bus.cfg_err, 0);
      go();
      for (int k = 1; k <= 9; k++) step();
      chk("p9_cnt", bus.count, 9);
      chk("p9_nodone", bus.done_pulse, 0);
      step();
      chk("p9_done", bus.done_pulse, 1);
      chk("p9_hold", bus.count, 9);

      // period lowered below count while paused: wrap through 15 to 0
      do_reset();
      cfg(7, 0, MODE_ONESHOT);
      go();
      for (int k = 1; k <= 5; k++) step();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      cfg(3, 0, MODE_ONESHOT);
      chk("wr_cfg_paused", bus.cfg_err, 0);
      go();
      chk("wr_resume", bus.count, 5);
      for (int k = 6; k <= 15; k++) begin
         step();
         chk("wr_cnt", bus.count, k);
      end
      step();
      chk("wr_zero", bus.count, 0);
      step(); step(); step();
      chk("wr_cnt3", bus.count, 3);
      chk("wr_nodone", bus.done_pulse, 0);
      step();
      chk("wr_done", bus.done_pulse, 1);

      // async reset mid-count
      do_reset();
      cfg(10, 0, MODE_RELOAD);
      go();
      for (int k = 1; k <= 6; k++) step();
      chk("ar_cnt6", bus.count, 6);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_count", bus.count, 0);
      chk("ar_busy", bus.busy, 0);
      chk("ar_irq", bus.irq, 0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("ar_idle_busy", bus.busy, 0);
      chk("ar_idle_cnt", bus.count, 0);
      chk("ar_idle_done", bus.done_pulse, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
